vga_scan_timing: RTL

//  Display-side counterpart of the raymarcher: generates the raster scan (pixel_x/pixel_y) consumed by the shader,

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_scan_timing_if.sv | 32 +++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_scan_timing.sv | 108 ++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA scan/sync path (640x480@60 defaults).
// Coordinate width comes from the `CORDW macro (default 10).
`ifndef CORDW
`define CORDW 10
`endif

package vga_timing_pkg;

    localparam int unsigned CordW = `CORDW;

    localparam int unsigned HActive = 640;
    localparam int unsigned HFp     = 16;
    localparam int unsigned HSync   = 96;
    localparam int unsigned HBp     = 48;
    localparam int unsigned VActive = 480;
    localparam int unsigned VFp     = 10;
    localparam int unsigned VSync   = 2;
    localparam int unsigned VBp     = 33;

    localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
    localparam int unsigned VTotal = VActive + VFp + VSync + VBp;

    localparam bit          SyncPolDefault = 1'b0;
    localparam int unsigned PipeLatDefault = 2;

    typedef logic [CordW-1:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    function automatic logic in_window(input coord_t pos, input int unsigned lo,
                                       input int unsigned hi);
        return (32'(pos) >= lo) && (32'(pos) < hi);
    endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// Scan coordinates out to the shader, colour back in, and the aligned VGA outputs.
// master = timing generator, slave = shader/display side.
interface vga_scan_timing_if;

    vga_timing_pkg::coord_t pixel_x;
    vga_timing_pkg::coord_t pixel_y;
    logic                   pixel_active;
    logic                   line_start;
    logic                   frame_start;
    logic [7:0]             red_in;
    logic [7:0]             green_in;
    logic [7:0]             blue_in;
    logic [7:0]             vga_r;
    logic [7:0]             vga_g;
    logic [7:0]             vga_b;
    logic                   vga_hs;
    logic                   vga_vs;
    logic                   vga_de;

    modport master (
        output pixel_x, pixel_y, pixel_active, line_start, frame_start,
        input  red_in, green_in, blue_in,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de
    );

    modport slave (
        input  pixel_x, pixel_y, pixel_active, line_start, frame_start,
        output red_in, green_in, blue_in,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de
    );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a loadable reset value; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] reset_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;

        logic unused_ok;
        assign unused_ok = ^{clk, rst, reset_val_i};
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= reset_val_i;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_scan_timing.sv
// Raster scan generator with sync/DE delay-matched to a fixed-latency shader pipeline.
// Optional: define VGA_BLANK_RGB_EN to force RGB to zero outside the delayed data-enable.
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = HActive,
    parameter int unsigned H_FP     = HFp,
    parameter int unsigned H_SYNC   = HSync,
    parameter int unsigned H_BP     = HBp,
    parameter int unsigned V_ACTIVE = VActive,
    parameter int unsigned V_FP     = VFp,
    parameter int unsigned V_SYNC   = VSync,
    parameter int unsigned V_BP     = VBp,
    parameter bit          SYNC_POL = SyncPolDefault,
    parameter int unsigned PIPE_LAT = PipeLatDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_scan_timing_if.master    vga
);

    localparam int unsigned HTot       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
    localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
    localparam sync_t       SyncIdle   = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0};

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    logic   h_last, v_last;

    sync_t  sync_raw, sync_dly;
    sync_t  sync_q;
    logic [23:0] rgb_d, rgb_q;

    always_comb begin
        h_last  = (32'(h_cnt_q) == HTot - 1);
        v_last  = (32'(v_cnt_q) == VTot - 1);
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        sync_raw.hs = in_window(h_cnt_q, HSyncStart, HSyncStart + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        sync_raw.vs = in_window(v_cnt_q, VSyncStart, VSyncStart + V_SYNC) ? SYNC_POL : ~SYNC_POL;
        sync_raw.de = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    end

    // Sync/DE wait out the shader latency so they meet the matching colour at the output reg.
    vga_delay_line #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (PIPE_LAT)
    ) u_sync_dly (
        .clk         (clk),
        .rst         (rst),
        .reset_val_i (SyncIdle),
        .d_i         (sync_raw),
        .q_o         (sync_dly)
    );

    always_comb begin
        rgb_d = {vga.red_in, vga.green_in, vga.blue_in};
`ifdef VGA_BLANK_RGB_EN
        if (!sync_dly.de) begin
            rgb_d = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q  <= '0;
            sync_q <= SyncIdle;
        end else begin
            rgb_q  <= rgb_d;
            sync_q <= sync_dly;
        end
    end

    always_comb begin
        vga.pixel_x      = h_cnt_q;
        vga.pixel_y      = v_cnt_q;
        vga.pixel_active = sync_raw.de;
        vga.line_start   = (h_cnt_q == '0);
        vga.frame_start  = (h_cnt_q == '0) && (v_cnt_q == '0);
        vga.vga_r        = rgb_q[23:16];
        vga.vga_g        = rgb_q[15:8];
        vga.vga_b        = rgb_q[7:0];
        vga.vga_hs       = sync_q.hs;
        vga.vga_vs       = sync_q.vs;
        vga.vga_de       = sync_q.de;
    end

endmodule
